bus_addr_decoder: RTL and testbench

//  Parametrised, registered address decoder and access sequencer between one bus master and NREG slaves (ROM, RAM, peripherals).

---
 rtl/bus_addr_decoder_if.sv | 55 +++++
 rtl/bus_addr_decoder.sv | 169 ++++++++++++++++
 tb/tb_bus_addr_decoder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_addr_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_addr_decoder_if
// Description : Bundle of the master-side request/response signals and the
//               slave-side select/acknowledge signals that pass through
//               bus_addr_decoder.
//               slave modport  : the decoder's view of the signals.
//               master modport : the surrounding system's view (the CPU that
//                                drives requests, and the slaves that return
//                                s_ack).
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_addr_decoder_if #(
    parameter int ADDR_W = 12,
    parameter int NREG   = 2
);

    // CPU side
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic              m_ack;
    logic              m_err;
    logic              busy;
    logic [ADDR_W-1:0] err_addr;

    // Slave side
    logic [NREG-1:0]   s_sel;
    logic [NREG-1:0]   s_ack;

    // The surrounding system drives requests and slave strobes.
    modport master (
        output m_req,
        output m_addr,
        output s_ack,
        input  m_ack,
        input  m_err,
        input  busy,
        input  err_addr,
        input  s_sel
    );

    // The decoder consumes requests and slave strobes.
    modport slave (
        input  m_req,
        input  m_addr,
        input  s_ack,
        output m_ack,
        output m_err,
        output busy,
        output err_addr,
        output s_sel
    );

endinterface
`default_nettype wire

// File: rtl/bus_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bus_addr_decoder
// Description : Registered address decoder and access sequencer between one
//               bus master and NREG slaves.
//               - Each region is a base/mask pair.
//               - The lowest index wins when regions overlap.
//               - Every access runs a req/ack handshake.
//               - An unmapped address returns a one-cycle m_err.
//               Optional feature macro ADDR_DEC_TIMEOUT_EN: an access that
//               sees no slave ack within TIMEOUT cycles is aborted with m_err.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_addr_decoder #(
    parameter int                      ADDR_W   = 12,
    parameter int                      NREG     = 2,
    parameter logic [NREG*ADDR_W-1:0]  REG_BASE = {12'h000, 12'h800},
    parameter logic [NREG*ADDR_W-1:0]  REG_MASK = {12'h800, 12'hC00},
    parameter int                      TIMEOUT  = 15
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bus_addr_decoder_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------------
    localparam bit c_param_ok = (NREG >= 1) && (NREG <= 8) && (TIMEOUT >= 1);

    if (!c_param_ok) begin : g_param_check
        $error("bus_addr_decoder: NREG must be 1..8 and TIMEOUT >= 1");
    end

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t             r_state;
    logic [NREG-1:0]    r_sel;
    logic               r_ack;
    logic               r_err;
    logic               r_busy;
    logic [ADDR_W-1:0]  r_err_addr;

`ifdef ADDR_DEC_TIMEOUT_EN
    // The counter must hold values up to TIMEOUT-1.
    localparam int                c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    // The timeout abort reports the captured address, not the live bus.
    logic [ADDR_W-1:0]  r_addr;
`endif

    // ------------------------------------------------------------------------
    // Region decode (combinational, from the live master address)
    // ------------------------------------------------------------------------
    logic [NREG-1:0] w_hit;
    logic [NREG-1:0] w_sel_nxt;
    logic            w_any_hit;
    logic            w_slave_ack;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_region
        localparam logic [ADDR_W-1:0] c_base = REG_BASE[gi*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] c_mask = REG_MASK[gi*ADDR_W +: ADDR_W];

        assign w_hit[gi] = ((bus.m_addr & c_mask) == (c_base & c_mask));
    end

    // Isolate the lowest set bit: the lowest-index hit wins, so the select
    // is one-hot or zero.
    assign w_sel_nxt = w_hit & (~w_hit + NREG'(1));
    assign w_any_hit = |w_hit;

    // Only the strobe of the currently selected slave completes an access.
    assign w_slave_ack = |(bus.s_ack & r_sel);

    // ------------------------------------------------------------------------
    // Access sequencer: state, select, response pulses and error address
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_err_addr <= '0;
`ifdef ADDR_DEC_TIMEOUT_EN
            r_cnt      <= '0;
            r_addr     <= '0;
`endif
        end else begin
            // Response strobes are single-cycle pulses by default.
            r_ack <= 1'b0;
            r_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.m_req) begin
                        r_busy <= 1'b1;
`ifdef ADDR_DEC_TIMEOUT_EN
                        r_addr <= bus.m_addr;
                        r_cnt  <= '0;
`endif
                        if (w_any_hit) begin
                            r_state <= S_ACCESS;
                            r_sel   <= w_sel_nxt;
                        end else begin
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_err_addr <= bus.m_addr;
                        end
                    end
                end

                S_ACCESS: begin
                    // A slave ack has priority over a simultaneous timeout.
                    if (w_slave_ack) begin
                        r_state <= S_RESP;
                        r_sel   <= '0;
                        r_ack   <= 1'b1;
                    end
`ifdef ADDR_DEC_TIMEOUT_EN
                    else if (r_cnt == c_cnt_last) begin
                        r_state    <= S_ERR;
                        r_sel      <= '0;
                        r_err      <= 1'b1;
                        r_err_addr <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
`endif
                end

                // The response pulse occupies this cycle; the next request
                // is sampled back in IDLE.
                S_RESP, S_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_sel   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------------
    assign bus.s_sel    = r_sel;
    assign bus.m_ack    = r_ack;
    assign bus.m_err    = r_err;
    assign bus.busy     = r_busy;
    assign bus.err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_bus_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_addr_decoder
// Description : Self-checking bench for bus_addr_decoder. It uses a
//               region-lookup reference model and runs directed plus
//               randomized accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_addr_decoder;

    localparam int               AW      = 12;
    localparam int               NR      = 2;
    localparam int               TO      = 4;
    localparam logic [NR*AW-1:0] BASE    = {12'h000, 12'h800};
    localparam logic [NR*AW-1:0] MASK    = {12'h800, 12'hC00};
    localparam logic [NR*AW-1:0] MASK_OV = {12'h000, 12'hC00};
`ifdef ADDR_DEC_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [AW-1:0] exp_err_addr;

    bus_addr_decoder_if #(.ADDR_W(AW), .NREG(NR)) bif  ();
    bus_addr_decoder_if #(.ADDR_W(AW), .NREG(NR)) bif2 ();

    bus_addr_decoder #(
        .ADDR_W(AW), .NREG(NR), .REG_BASE(BASE), .REG_MASK(MASK), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bif)
    );

    bus_addr_decoder #(
        .ADDR_W(AW), .NREG(NR), .REG_BASE(BASE), .REG_MASK(MASK_OV), .TIMEOUT(TO)
    ) dut_ov (
        .clk(clk), .rst(rst), .bus(bif2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: index of the first region whose masked base matches, or -1.
    function automatic int region_of(input logic [AW-1:0] a, input logic [NR*AW-1:0] mask);
        int            r;
        logic [AW-1:0] b;
        logic [AW-1:0] m;
        r = -1;
        for (int i = 0; i < NR; i++) begin
            b = AW'(BASE >> (i * AW));
            m = AW'(mask >> (i * AW));
            if (r < 0 && ((a & m) == (b & m)))
                r = i;
        end
        return r;
    endfunction

    // One complete access on the main DUT.
    // d     : number of ACCESS cycles before the slave acks.
    // stray : drive the unselected slave's ack while waiting.
    task automatic do_access(input logic [AW-1:0] addr, input int d, input bit stray);
        int           r;
        logic [NR-1:0] oh;
        r = region_of(addr, MASK);
        check_eq("idle_busy", bif.busy, 0);
        check_eq("err_addr_hold", bif.err_addr, exp_err_addr);
        bif.m_req  = 1'b1;
        bif.m_addr = addr;
        @(negedge clk);
        bif.m_addr = AW'($urandom);
        if (r < 0) begin
            check_eq("miss_err", bif.m_err, 1);
            check_eq("miss_ack", bif.m_ack, 0);
            check_eq("miss_sel", bif.s_sel, 0);
            check_eq("miss_busy", bif.busy, 1);
            check_eq("miss_err_addr", bif.err_addr, addr);
            exp_err_addr = addr;
        end else begin
            oh = NR'(1) << r;
            check_eq("hit_sel", bif.s_sel, oh);
            check_eq("hit_busy", bif.busy, 1);
            check_eq("hit_ack_early", bif.m_ack, 0);
            for (int k = 1; k <= d + 1; k++) begin
                bif.s_ack = (k == d + 1) ? oh : (stray ? ~oh : '0);
                @(negedge clk);
                bif.s_ack = '0;
                if (k == d + 1) begin
                    check_eq("resp_ack", bif.m_ack, 1);
                    check_eq("resp_err", bif.m_err, 0);
                    check_eq("resp_sel", bif.s_sel, 0);
                    break;
                end else if (TEN && k == TO) begin
                    check_eq("to_err", bif.m_err, 1);
                    check_eq("to_ack", bif.m_ack, 0);
                    check_eq("to_sel", bif.s_sel, 0);
                    check_eq("to_err_addr", bif.err_addr, addr);
                    exp_err_addr = addr;
                    break;
                end else begin
                    check_eq("wait_sel", bif.s_sel, oh);
                    check_eq("wait_busy", bif.busy, 1);
                    check_eq("wait_ack", bif.m_ack, 0);
                    check_eq("wait_err", bif.m_err, 0);
                end
            end
        end
        bif.m_req = 1'b0;
        @(negedge clk);
        check_eq("post_ack", bif.m_ack, 0);
        check_eq("post_err", bif.m_err, 0);
        check_eq("post_busy", bif.busy, 0);
        check_eq("post_sel", bif.s_sel, 0);
    endtask

    // m_ack and m_err must never be high together.
    always @(negedge clk) begin
        if (!rst)
            check_eq("ack_err_excl", bif.m_ack & bif.m_err, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            r;
        logic [AW-1:0] a;
        bif.m_req   = 1'b0;
        bif.m_addr  = '0;
        bif.s_ack   = '0;
        bif2.m_req  = 1'b0;
        bif2.m_addr = '0;
        bif2.s_ack  = '0;
        exp_err_addr = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_sel", bif.s_sel, 0);
        check_eq("rst_ack", bif.m_ack, 0);
        check_eq("rst_err", bif.m_err, 0);
        check_eq("rst_busy", bif.busy, 0);
        check_eq("rst_err_addr", bif.err_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed accesses
        do_access(12'h123, 2, 1'b0);
        do_access(12'h9FF, 2, 1'b1);
        do_access(12'hC00, 0, 1'b0);
        do_access(12'h9FF, TO - 1, 1'b0);
        do_access(12'h400, 100, 1'b0);

        // Randomized accesses with idle gaps carrying random s_ack noise
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin
                bif.s_ack = NR'($urandom);
                @(negedge clk);
                check_eq("idle_noise_ack", bif.m_ack, 0);
                check_eq("idle_noise_busy", bif.busy, 0);
            end
            bif.s_ack = '0;
            do_access(AW'($urandom), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of an access
        bif.m_req  = 1'b1;
        bif.m_addr = 12'h456;
        @(negedge clk);
        check_eq("pre_rst_sel", bif.s_sel, 2'b10);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_sel", bif.s_sel, 0);
        check_eq("async_rst_busy", bif.busy, 0);
        check_eq("async_rst_ack", bif.m_ack, 0);
        check_eq("async_rst_err", bif.m_err, 0);
        check_eq("async_rst_err_addr", bif.err_addr, 0);
        #1 rst = 1'b0;
        bif.m_req    = 1'b0;
        exp_err_addr = '0;
        @(negedge clk);
        do_access(12'h000, 1, 1'b0);

        // Overlapping regions on the mask-override instance
        for (int t = 0; t < 2; t++) begin
            a = (t == 0) ? 12'h800 : 12'h123;
            r = region_of(a, MASK_OV);
            bif2.m_req  = 1'b1;
            bif2.m_addr = a;
            @(negedge clk);
            check_eq("ov_sel", bif2.s_sel, NR'(1) << r);
            bif2.s_ack = NR'(1) << r;
            @(negedge clk);
            bif2.s_ack = '0;
            check_eq("ov_ack", bif2.m_ack, 1);
            bif2.m_req = 1'b0;
            @(negedge clk);
            check_eq("ov_idle", bif2.busy, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
